// File: rtl/ddr_writer.sv
// Drains conv-unit output buffers round-robin into 64-bit beats and sequences master-write commands.
// Optional statistics counters are enabled with `define DDR_WRITER_STATS_EN.
module ddr_writer #(
    parameter int unsigned N_CONV_UNIT = 4,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned UNIT_BURSTS = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              cfg_valid,
    input  logic [63:0]                       cfg_data,
    output logic                              cfg_ready,
    input  logic [N_CONV_UNIT-1:0]            ob_empty,
    input  logic [N_CONV_UNIT*DATA_WIDTH-1:0] ob_dout,
    output logic [N_CONV_UNIT-1:0]            ob_rd_en,
    output logic                              m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    input  logic                              m_axis_tready,
    output logic                              WSTART_REG,
    output logic [ADDR_WIDTH-1:0]             WADDR_REG,
    output logic [31:0]                       WNBURST_REG,
    input  logic                              WDONE_REG,
    output logic                              done,
    output logic [31:0]                       stat_beats,
    output logic [31:0]                       stat_stall
);

    localparam int unsigned SEL_W = (N_CONV_UNIT > 1) ? $clog2(N_CONV_UNIT) : 1;
    localparam int unsigned BYTES_PER_BURST = BURST_LEN * DATA_WIDTH / 8;

    typedef enum logic [2:0] {StIdle, StInit, StXfer, StIncr, StFin} state_t;

    state_t                  state_q, state_d;
    logic                    cfg_ready_q;
    logic [ADDR_WIDTH-1:0]   base_q, addr_q;
    logic [17:0]             nbursts_q, rema_q, chunk_q;
    logic [24:0]             valid_beats_q, total_beats_q;
    logic [11:0]             beats_sent_q, chunk_beats_q;
    logic [SEL_W-1:0]        sel_q;
    logic                    tvalid_q;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic                    wdone_seen_q;

    logic [DATA_WIDTH-1:0]   heads [N_CONV_UNIT];
    logic [24:0]             cfg_last_beats, cfg_valid_beats;
    logic [17:0]             chunk_src, chunk_next;
    logic                    accept, data_phase, cur_empty, room, hs, load, pop, xfer_done;
    logic                    unused_cfg;

    assign unused_cfg = ^cfg_data[63:57];

    always_comb begin
        for (int i = 0; i < N_CONV_UNIT; i++) begin
            heads[i] = ob_dout[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A last-burst byte count of 0 stands for a full burst.
    assign cfg_last_beats  = (cfg_data[38:32] == 7'd0) ? 25'(BURST_LEN)
                                                       : (25'(cfg_data[38:32]) + 25'd7) >> 3;
    assign cfg_valid_beats = (25'(cfg_data[56:39]) - 25'd1) * 25'(BURST_LEN) + cfg_last_beats;

    assign accept     = (state_q == StIdle) & cfg_ready_q & cfg_valid;
    assign chunk_src  = (state_q == StInit) ? nbursts_q : rema_q;
    assign chunk_next = (chunk_src > 18'(UNIT_BURSTS)) ? 18'(UNIT_BURSTS) : chunk_src;
    assign data_phase = total_beats_q < valid_beats_q;
    assign cur_empty  = ob_empty[sel_q];
    assign room       = (beats_sent_q + {11'd0, tvalid_q}) < chunk_beats_q;
    assign hs         = tvalid_q & m_axis_tready;
    assign load       = (state_q == StXfer) & room & (~tvalid_q | m_axis_tready)
                        & (~data_phase | ~cur_empty);
    assign pop        = load & data_phase;
    assign xfer_done  = (WDONE_REG | wdone_seen_q) & (beats_sent_q == chunk_beats_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StInit;
            StInit: state_d = (nbursts_q == 18'd0) ? StFin : StXfer;
            StXfer: if (xfer_done) state_d = (rema_q != 18'd0) ? StIncr : StFin;
            StIncr: state_d = StXfer;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= (state_d == StIdle);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q        <= '0;
            addr_q        <= '0;
            nbursts_q     <= '0;
            rema_q        <= '0;
            chunk_q       <= '0;
            valid_beats_q <= '0;
            total_beats_q <= '0;
            beats_sent_q  <= '0;
            chunk_beats_q <= '0;
            sel_q         <= '0;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            wdone_seen_q  <= 1'b0;
        end else begin
            if (accept) begin
                base_q        <= cfg_data[ADDR_WIDTH-1:0];
                nbursts_q     <= cfg_data[56:39];
                valid_beats_q <= cfg_valid_beats;
            end
            if (state_q == StInit || state_q == StIncr) begin
                chunk_q       <= chunk_next;
                rema_q        <= chunk_src - chunk_next;
                chunk_beats_q <= 12'(chunk_next * BURST_LEN);
                beats_sent_q  <= '0;
                wdone_seen_q  <= 1'b0;
                addr_q        <= (state_q == StInit) ? base_q
                                 : addr_q + ADDR_WIDTH'(chunk_q * BYTES_PER_BURST);
            end
            if (state_q == StInit) begin
                sel_q         <= '0;
                total_beats_q <= '0;
            end
            if (state_q == StXfer && WDONE_REG) begin
                wdone_seen_q <= 1'b1;
            end
            if (hs) begin
                beats_sent_q <= beats_sent_q + 12'd1;
            end
            if (load) begin
                tvalid_q      <= 1'b1;
                tdata_q       <= data_phase ? heads[sel_q] : '0;
                total_beats_q <= total_beats_q + 25'd1;
                if (data_phase) begin
                    sel_q <= (sel_q == SEL_W'(N_CONV_UNIT - 1)) ? '0 : sel_q + 1'b1;
                end
            end else if (hs) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        ob_rd_en = '0;
        if (pop) ob_rd_en[sel_q] = 1'b1;
    end

    assign cfg_ready     = cfg_ready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign WSTART_REG    = (state_q == StXfer);
    assign WADDR_REG     = WSTART_REG ? addr_q : '0;
    assign WNBURST_REG   = WSTART_REG ? 32'(chunk_q) : 32'd0;
    assign done          = (state_q == StFin);

`ifdef DDR_WRITER_STATS_EN
    logic [31:0] stat_beats_q, stat_stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_beats_q <= '0;
            stat_stall_q <= '0;
        end else if (state_q == StInit) begin
            stat_beats_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (hs && stat_beats_q != '1) stat_beats_q <= stat_beats_q + 32'd1;
            if (state_q == StXfer && data_phase && cur_empty && stat_stall_q != '1) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_stall = stat_stall_q;
`else
    assign stat_beats = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_ddr_writer.sv
// Bench for ddr_writer: region-level beat/command model, master-write responder, directed regions.
module tb_ddr_writer;

    localparam int N  = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [63:0]   cfg_data = '0;
    logic          cfg_ready;
    logic [N-1:0]  ob_empty = '0;
    logic [N*DW-1:0] ob_dout;
    logic [N-1:0]  ob_rd_en;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tready = 1'b1;
    logic          WSTART_REG;
    logic [31:0]   WADDR_REG;
    logic [31:0]   WNBURST_REG;
    logic          WDONE_REG = 1'b0;
    logic          done;
    logic [31:0]   stat_beats, stat_stall;

    always #5 clk = ~clk;

    ddr_writer dut (
        .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .ob_empty(ob_empty), .ob_dout(ob_dout), .ob_rd_en(ob_rd_en),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tready(m_axis_tready), .WSTART_REG(WSTART_REG), .WADDR_REG(WADDR_REG),
        .WNBURST_REG(WNBURST_REG), .WDONE_REG(WDONE_REG), .done(done),
        .stat_beats(stat_beats), .stat_stall(stat_stall)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] nb;
    } cmd_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Output buffers: word i of unit u is tagged with u and i so order errors are visible.
    int popcnt [N];
    function automatic logic [63:0] word(int u, int i);
        return {8'(8'hA0 + u), 24'h0, 32'(i)};
    endfunction

    initial for (int u = 0; u < N; u++) popcnt[u] = 0;
    always @(posedge clk) for (int u = 0; u < N; u++) if (ob_rd_en[u]) popcnt[u] <= popcnt[u] + 1;
    always_comb for (int u = 0; u < N; u++) ob_dout[u*DW +: DW] = word(u, popcnt[u]);

    logic [63:0] exp_beats[$];
    cmd_t        exp_cmds[$];

    int          region_beats, region_zero, region_cmds, done_cnt;
    logic [63:0] fb0, fb1;
    logic [31:0] last_addr, last_nb;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        cmd_busy, sent, early;
    int          cmd_cnt, target;

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Expected stream: beat k of a region comes from unit k%4 (its next word), or zero once padding.
    task automatic plan(int base, int n, int lb);
        int valid, rem, a, c;
        cmd_t cmd;
        valid = (n == 0) ? 0 : (n - 1) * 16 + ((lb == 0) ? 16 : (lb + 7) / 8);
        for (int k = 0; k < n * 16; k++) begin
            if (k < valid) exp_beats.push_back(word(k % 4, popcnt[k % 4] + k / 4));
            else exp_beats.push_back(64'd0);
        end
        rem = n;
        a = base;
        while (rem > 0) begin
            c = (rem > 16) ? 16 : rem;
            cmd.a = 32'(a);
            cmd.nb = 32'(c);
            exp_cmds.push_back(cmd);
            a += c * 128;
            rem -= c;
        end
    endtask

    // Monitor and master-write responder, both evaluated on the falling edge.
    initial begin
        logic hs;
        logic [63:0] w;
        cmd_t c;
        forever begin
            @(negedge clk);
            if (rstn) begin
                hs = m_axis_tvalid & m_axis_tready;
                if (prev_stall) begin
                    check("hold_valid", 64'(m_axis_tvalid), 64'd1);
                    check("hold_data", m_axis_tdata, prev_data);
                end
                prev_stall = m_axis_tvalid & ~m_axis_tready;
                prev_data  = m_axis_tdata;
                if (hs) begin
                    if (exp_beats.size() == 0) check("extra_beat", 64'd1, 64'd0);
                    else begin
                        w = exp_beats.pop_front();
                        check("beat", m_axis_tdata, w);
                    end
                    if (region_beats == 0) fb0 = m_axis_tdata;
                    if (region_beats == 1) fb1 = m_axis_tdata;
                    region_beats++;
                    if (m_axis_tdata == 64'd0) region_zero++;
                end
                check("pop_empty", 64'(ob_rd_en & ob_empty), 64'd0);
                check("rd_onehot", 64'($countones(ob_rd_en) <= 1), 64'd1);
                if (!WSTART_REG) check("cmd_idle", {WADDR_REG, WNBURST_REG}, 64'd0);
                if (done) done_cnt++;

                if (WDONE_REG) WDONE_REG = 1'b0;
                if (!cmd_busy && WSTART_REG) begin
                    cmd_busy = 1'b1;
                    cmd_cnt = 0;
                    sent = 1'b0;
                    target = int'(WNBURST_REG) * 16;
                    region_cmds++;
                    last_addr = WADDR_REG;
                    last_nb = WNBURST_REG;
                    if (exp_cmds.size() == 0) check("extra_cmd", 64'd1, 64'd0);
                    else begin
                        c = exp_cmds.pop_front();
                        check("cmd_addr", 64'(WADDR_REG), 64'(c.a));
                        check("cmd_nb", 64'(WNBURST_REG), 64'(c.nb));
                    end
                end else if (cmd_busy && !WSTART_REG) begin
                    cmd_busy = 1'b0;
                end
                if (cmd_busy && !sent && cmd_cnt >= target - (early ? 2 : 0)) begin
                    WDONE_REG = 1'b1;
                    sent = 1'b1;
                end
                if (cmd_busy && hs) cmd_cnt++;
            end
        end
    end

    task automatic start_region(int base, int n, int lb);
        check("cfg_ready_idle", 64'(cfg_ready), 64'd1);
        plan(base, n, lb);
        region_beats = 0;
        region_zero = 0;
        region_cmds = 0;
        done_cnt = 0;
        cfg_data = {7'd0, 18'(n), 7'(lb), 32'(base)};
        cfg_valid = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic wait_done(string name, int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) check({name, "_timeout"}, 64'd1, 64'd0);
        @(posedge clk);
        #1;
        check({name, "_ready"}, 64'(cfg_ready), 64'd1);
        check({name, "_beats_left"}, 64'(exp_beats.size()), 64'd0);
        check({name, "_cmds_left"}, 64'(exp_cmds.size()), 64'd0);
        check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int pops0;
        prev_stall = 1'b0;
        cmd_busy = 1'b0;
        sent = 1'b0;
        early = 1'b0;
        cmd_cnt = 0;
        target = 0;
        #1;
        check("rst_ready", 64'(cfg_ready), 64'd0);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_wstart", 64'(WSTART_REG), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(ob_rd_en), 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Two full bursts, one command.
        start_region(32'h1000, 2, 0);
        wait_done("t1", 500);
        check("t1_nbeats", 64'(region_beats), 64'd32);
        check("t1_nzero", 64'(region_zero), 64'd0);
        check("t1_ncmds", 64'(region_cmds), 64'd1);
        check("t1_addr", 64'(last_addr), 64'h1000);
        check("t1_nb", 64'(last_nb), 64'd2);
        check("t1_beat0", fb0, 64'hA000_0000_0000_0000);
        check("t1_beat1", fb1, 64'hA100_0000_0000_0000);

        // Split into 16 + 4 bursts.
        start_region(32'h1000, 20, 0);
        wait_done("t2", 2000);
        check("t2_nbeats", 64'(region_beats), 64'd320);
        check("t2_ncmds", 64'(region_cmds), 64'd2);
        check("t2_addr", 64'(last_addr), 64'h1800);
        check("t2_nb", 64'(last_nb), 64'd4);

        // 20 valid bytes: 3 data beats then 13 pads.
        pops0 = popcnt[0] + popcnt[1] + popcnt[2] + popcnt[3];
        start_region(32'h3000, 1, 20);
        wait_done("t3", 500);
        check("t3_pops", 64'(popcnt[0] + popcnt[1] + popcnt[2] + popcnt[3] - pops0), 64'd3);
        check("t3_nbeats", 64'(region_beats), 64'd16);
        check("t3_nzero", 64'(region_zero), 64'd13);

        // Backpressure plus unit 2 empty for 10 cycles.
        start_region(32'h4000, 2, 0);
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    m_axis_tready = (i % 2 == 0);
                    @(posedge clk);
                    #1;
                end
                m_axis_tready = 1'b1;
            end
            begin
                int k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!ob_rd_en[1] && k < 200);
                if (k >= 200) check("t4_pop1_timeout", 64'd1, 64'd0);
                @(posedge clk);
                #1 ob_empty = 4'b0100;
                repeat (10) @(posedge clk);
                #1 ob_empty = 4'b0000;
            end
        join
        wait_done("t4", 1000);
        check("t4_nbeats", 64'(region_beats), 64'd32);
        check("t4_fb0_unit", 64'(fb0[63:56]), 64'hA0);
`ifdef DDR_WRITER_STATS_EN
        check("t4_stat_stall", 64'(stat_stall), 64'd10);
        check("t4_stat_beats", 64'(stat_beats), 64'd32);
`else
        check("t4_stat_stall", 64'(stat_stall), 64'd0);
        check("t4_stat_beats", 64'(stat_beats), 64'd0);
`endif

        // WDONE_REG ahead of the last beat, across an INCR and into FIN.
        early = 1'b1;
        start_region(32'h5000, 17, 8);
        wait_done("t5", 2000);
        check("t5_nbeats", 64'(region_beats), 64'd272);
        check("t5_nzero", 64'(region_zero), 64'd15);
        check("t5_ncmds", 64'(region_cmds), 64'd2);
        check("t5_addr", 64'(last_addr), 64'h5800);
        check("t5_nb", 64'(last_nb), 64'd1);
        start_region(32'h5000, 1, 0);
        wait_done("t5b", 500);
        check("t5b_nbeats", 64'(region_beats), 64'd16);
        early = 1'b0;

        // Zero bursts: INIT then FIN, no command.
        start_region(32'h2000, 0, 0);
        @(negedge clk);
        check("t6_init_done", 64'(done), 64'd0);
        @(negedge clk);
        check("t6_fin_done", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        check("t6_ready", 64'(cfg_ready), 64'd1);
        check("t6_ncmds", 64'(region_cmds), 64'd0);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);

        // Reset in the middle of a transfer.
        start_region(32'h6000, 4, 0);
        repeat (20) @(posedge clk);
        #1;
        check("t7_pre_wstart", 64'(WSTART_REG), 64'd1);
        rstn = 1'b0;
        #1;
        check("t7_wstart", 64'(WSTART_REG), 64'd0);
        check("t7_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t7_rd_en", 64'(ob_rd_en), 64'd0);
        check("t7_waddr", 64'(WADDR_REG), 64'd0);
        exp_beats.delete();
        exp_cmds.delete();
        cmd_busy = 1'b0;
        prev_stall = 1'b0;
        WDONE_REG = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        check("t7_ready", 64'(cfg_ready), 64'd1);
        start_region(32'h7000, 1, 0);
        wait_done("t7b", 500);
        check("t7b_fb0_unit", 64'(fb0[63:56]), 64'hA0);
        check("t7b_fb1_unit", 64'(fb1[63:56]), 64'hA1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
